pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage RV64 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB regs).
//  Resolves load-use hazards, branch redirects, multi-cycle MDU ops, data-memory waits and traps.
//  Drives per-register enable/flush and PC control. Flush = load the register's bubble (reset) value.
// PARAMETERS
//  TRAP_DRAIN_CYC  2  cycles spent in TRAP_DRAIN before PC takes trap vector (legal 1..15)
//  PERF_W          32 width of perf counters (used only with PIPE_CTRL_PERF_EN)
// PORTS
//  clk            in   1  clock
//  rst            in   1  synchronous, active-low reset
//  id_rs1/id_rs2  in   5  ID-stage source regs; id_rs1_used/id_rs2_used in 1: source actually read
//  ex_rd          in   5  EX-stage dest reg; ex_is_load in 1: EX holds a load
//  ex_redirect    in   1  EX resolved taken branch/jump mispredict
//  ex_mdu_start   in   1  multi-cycle MUL/DIV in EX; mdu_done in 1: result valid this cycle
//  mem_req        in   1  MEM stage has load/store; mem_ready in 1: data memory ack
//  if_valid       in   1  fetch data valid this cycle
//  trap           in   1  trap request (level, held by source until trap_ack)
//  pc_en/pc_sel   out  1/2 PC write enable; select 00 seq, 01 redirect, 10 trap vector
//  ifid_en/ifid_flush, idex_en/idex_flush, exmem_en/exmem_flush, memwb_en/memwb_flush  out 1 each
//  trap_ack       out  1  one-cycle pulse when trap vector is loaded
//  mdu_kill       out  1  abort in-flight MDU op
//  state          out  2  FSM state (debug)
//  perf_stall_cnt/perf_flush_cnt  out PERF_W  perf counters
// BEHAVIOUR
//  FSM: RUN=0, MEM_WAIT=1, MDU_WAIT=2, TRAP_DRAIN=3. Outputs Mealy (state+inputs); flush overrides en.
//  Reset (rst=0): next state RUN, drain cnt 0; while rst=0 all *_en=0, all *_flush=1, pc_en=0,
//   pc_sel=00, trap_ack=0, mdu_kill=0. Reset mid-wait abandons MEM/MDU wait silently.
//  Default (no condition): all en=1, flush=0, pc_en=1, pc_sel=00.
//  RUN priority, highest first:
//   1 trap: flush all 4 regs, pc_en=0, drain cnt<=TRAP_DRAIN_CYC-1, ->TRAP_DRAIN.
//   2 mem_req&!mem_ready: pc/ifid/idex/exmem en=0, memwb_flush=1, ->MEM_WAIT.
//   3 ex_mdu_start&!mdu_done: pc/ifid/idex en=0, exmem_flush=1, memwb_en=1, ->MDU_WAIT.
//   4 ex_redirect: pc_en=1, pc_sel=01, ifid_flush=1, idex_flush=1 (beats load-use).
//   5 load-use: ex_is_load & ex_rd!=0 & ((rs1_used&rs1==ex_rd)|(rs2_used&rs2==ex_rd)):
//     pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble.
//   6 !if_valid: pc_en=0, ifid_flush=1; downstream advances.
//  Same-cycle mem_ready or mdu_done: condition absent, evaluate lower priorities (0-cycle stall).
//  MEM_WAIT: stall outputs of rule 2 while !mem_ready; trap ignored (not acked) here. When
//   mem_ready=1: evaluate RUN table that cycle (incl. trap) and take its next state.
//  MDU_WAIT: rule-3 outputs while !mdu_done. trap: mdu_kill=1 for 1 cycle, then as RUN rule 1.
//   mdu_done=1: evaluate RUN table with MDU condition cleared.
//  TRAP_DRAIN: all 4 flush=1, pc_en=0; cnt decrements; when cnt==0: pc_en=1, pc_sel=10,
//   trap_ack=1, ->RUN. trap held high during drain is not re-taken; re-assertion after ack is new.
//  Counter 4 bits, never wraps (TRAP_DRAIN_CYC<=15 checked by static assert in sim).
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: perf_stall_cnt += 1 each cycle with pc_en=0 outside reset;
//   perf_flush_cnt += 1 per redirect and per trap_ack; both saturate at all-ones, clear on reset.
//  Undefined: counters not built, perf ports tied to 0.
// TESTING
//  Load x5 in EX, ID reads rs1=5 -> 1 cycle pc_en=0, ifid_en=0, idex_flush=1; ex_rd=0 -> no stall.
//  Load-use + ex_redirect same cycle -> pc_sel=01, ifid/idex flush, pc_en=1, no stall.
//  mem_req=1, mem_ready low 3 cycles -> state=1 for 3 cycles, memwb_flush=1 each; 4th cycle all en=1.
//  trap in MEM_WAIT, mem_ready after 2 cycles -> no ack until then; drain 2 cycles, trap_ack, pc_sel=10.
//  DIV in MDU_WAIT + trap -> mdu_kill 1 cycle, TRAP_DRAIN, trap_ack after TRAP_DRAIN_CYC cycles.
//  rst=0 in MDU_WAIT -> next cycle state=0, all flush=1; PERF_EN: counters read 0, redirect -> flush=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline stall/flush/PC sequencer; define PIPE_CTRL_PERF_EN to build the perf counters
module pipe_ctrl #(
  parameter int TRAP_DRAIN_CYC = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [4:0]        ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  input  logic              ex_mdu_start,
  input  logic              mdu_done,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              if_valid,
  input  logic              trap,
  output logic              pc_en,
  output logic [1:0]        pc_sel,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              exmem_flush,
  output logic              memwb_en,
  output logic              memwb_flush,
  output logic              trap_ack,
  output logic              mdu_kill,
  output logic [1:0]        state,
  output logic [PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, MDU_WAIT = 2'd2, TRAP_DRAIN = 2'd3;
  localparam logic [3:0] DRAIN_INIT = 4'(TRAP_DRAIN_CYC - 1);
  if (TRAP_DRAIN_CYC < 1 || TRAP_DRAIN_CYC > 15) begin : g_bad_drain
    $error("pipe_ctrl: TRAP_DRAIN_CYC must be 1..15");
  end
  logic [1:0] st, nst;
  logic [3:0] cnt, ncnt;
  logic lu, mem_stall, mdu_stall, run, fall, drain, dz;
  logic a_trap, a_mem, a_mdu, a_redir, a_lu, a_nif;
  assign lu = ex_is_load & |ex_rd & ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign mem_stall = mem_req & !mem_ready;
  assign mdu_stall = ex_mdu_start & !mdu_done;
  // A wait state whose ack arrives this cycle behaves exactly like RUN (zero-cycle stall)
  assign run = (st == RUN) | ((st == MEM_WAIT) & mem_ready) | ((st == MDU_WAIT) & mdu_done);
  assign drain = st == TRAP_DRAIN;
  assign dz = drain & (cnt == 4'd0);
  assign a_trap = trap & (run | ((st == MDU_WAIT) & !mdu_done));
  assign a_mem = ((st == MEM_WAIT) & !mem_ready) | (run & !trap & mem_stall);
  assign a_mdu = ((st == MDU_WAIT) & !mdu_done & !trap) | (run & !trap & !mem_stall & mdu_stall);
  assign fall = run & !trap & !mem_stall & !mdu_stall;
  assign a_redir = fall & ex_redirect;
  assign a_lu = fall & !ex_redirect & lu;
  assign a_nif = fall & !ex_redirect & !lu & !if_valid;
  always_comb begin
    nst = a_trap ? TRAP_DRAIN : a_mem ? MEM_WAIT : a_mdu ? MDU_WAIT : (drain & !dz) ? TRAP_DRAIN : RUN;
    ncnt = a_trap ? DRAIN_INIT : (drain & !dz) ? cnt - 4'd1 : cnt;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= RUN;
      cnt <= '0;
    end else begin
      st <= nst;
      cnt <= ncnt;
    end
  end
  assign state = st;
  assign pc_en = rst & (dz | !(a_trap | a_mem | a_mdu | a_lu | a_nif | drain));
  assign pc_sel = !rst ? 2'b00 : dz ? 2'b10 : a_redir ? 2'b01 : 2'b00;
  assign ifid_en = rst & !(a_mem | a_mdu | a_lu);
  assign ifid_flush = !rst | a_trap | drain | a_redir | a_nif;
  assign idex_en = rst & !(a_mem | a_mdu);
  assign idex_flush = !rst | a_trap | drain | a_redir | a_lu;
  assign exmem_en = rst & !a_mem;
  assign exmem_flush = !rst | a_trap | drain | a_mdu;
  assign memwb_en = rst;
  assign memwb_flush = !rst | a_trap | drain | a_mem;
  assign trap_ack = rst & dz;
  assign mdu_kill = rst & (st == MDU_WAIT) & trap;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] ps, pf;
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps <= '0;
      pf <= '0;
    end else begin
      if (!pc_en && !(&ps)) ps <= ps + 1'b1;
      if ((pc_sel == 2'b01 || trap_ack) && !(&pf)) pf <= pf + 1'b1;
    end
  end
  assign perf_stall_cnt = ps;
  assign perf_flush_cnt = pf;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a priority-rule reference model
module tb_pipe_ctrl;
  localparam int D = 2;
  localparam int PW = 32;
  logic clk = 0, rst = 0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_is_load, ex_redirect, ex_mdu_start, mdu_done;
  logic mem_req, mem_ready, if_valid, trap;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush;
  logic memwb_en, memwb_flush, trap_ack, mdu_kill;
  logic [1:0] pc_sel, state;
  logic [PW-1:0] perf_stall_cnt, perf_flush_cnt;
  int tests = 0, fails = 0;
  int m_st, m_cnt, n_st, n_cnt;
  longint m_ps, m_pf;
  logic [14:0] exp;
  always #5 clk = ~clk;
  pipe_ctrl #(.TRAP_DRAIN_CYC(D), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .ex_mdu_start(ex_mdu_start), .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .if_valid(if_valid), .trap(trap), .pc_en(pc_en), .pc_sel(pc_sel), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush), .trap_ack(trap_ack),
    .mdu_kill(mdu_kill), .state(state), .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );
  function automatic logic [14:0] dut_out();
    return {pc_en, pc_sel, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
            memwb_en, memwb_flush, trap_ack, mdu_kill, state};
  endfunction
  function automatic logic [2*PW-1:0] exp_perf();
`ifdef PIPE_CTRL_PERF_EN
    return {PW'(m_ps), PW'(m_pf)};
`else
    return '0;
`endif
  endfunction
  // Reference: apply the first matching rule of the priority list; en/flush kept per register index
  task automatic model_eval();
    logic pe, ack, kill, lu;
    logic [1:0] sel;
    logic [3:0] en, fl;
    pe = 1; sel = 0; en = '1; fl = '0; ack = 0; kill = 0; n_st = 0; n_cnt = m_cnt;
    lu = ex_is_load && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (!rst) begin
      pe = 0; en = '0; fl = '1; n_cnt = 0;
    end else if (m_st == 3) begin
      fl = '1;
      if (m_cnt == 0) begin sel = 2; ack = 1; end
      else begin pe = 0; n_st = 3; n_cnt = m_cnt - 1; end
    end else if (m_st == 1 && !mem_ready) begin
      pe = 0; en[2:0] = '0; fl[3] = 1; n_st = 1;
    end else if (m_st == 2 && !mdu_done && !trap) begin
      pe = 0; en[1:0] = '0; fl[2] = 1; n_st = 2;
    end else begin
      kill = (m_st == 2) && trap;
      if (trap) begin fl = '1; pe = 0; n_st = 3; n_cnt = D - 1; end
      else if (mem_req && !mem_ready) begin pe = 0; en[2:0] = '0; fl[3] = 1; n_st = 1; end
      else if (ex_mdu_start && !mdu_done) begin pe = 0; en[1:0] = '0; fl[2] = 1; n_st = 2; end
      else if (ex_redirect) begin sel = 1; fl[1:0] = 2'b11; end
      else if (lu) begin pe = 0; en[0] = 0; fl[1] = 1; end
      else if (!if_valid) begin pe = 0; fl[0] = 1; end
    end
    exp = {pe, sel, en[0], fl[0], en[1], fl[1], en[2], fl[2], en[3], fl[3], ack, kill, 2'(m_st)};
  endtask
  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask
  task automatic advance();
    @(posedge clk);
    if (!rst) begin m_ps = 0; m_pf = 0; end
    else begin
      if (!exp[14] && m_ps < 64'hFFFF_FFFF) m_ps++;
      if ((exp[13:12] == 2'b01 || exp[3]) && m_pf < 64'hFFFF_FFFF) m_pf++;
    end
    m_st = n_st; m_cnt = n_cnt;
    #1;
  endtask
  task automatic idle();
    rst = 1; id_rs1 = 1; id_rs2 = 2; ex_rd = 3; id_rs1_used = 0; id_rs2_used = 0; ex_is_load = 0;
    ex_redirect = 0; ex_mdu_start = 0; mdu_done = 0; mem_req = 0; mem_ready = 0; if_valid = 1; trap = 0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      settle();
      if (dut_out() !== exp) begin fails++; $display("FAIL reset model: got %h exp %h", dut_out(), exp); end
      tests++;
      if ({pc_en, pc_sel, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, memwb_flush, trap_ack, mdu_kill, state} !== 15'b000_0000_1111_00_00) begin
        fails++; $display("FAIL reset outputs: got pc_en=%b en=%b%b%b%b state=%0d", pc_en, ifid_en, idex_en, exmem_en, memwb_en, state);
      end
      tests++;
      advance();
    end
    idle();
  endtask
  task automatic test_load_use();
    idle(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
    settle();
    if ({pc_en, ifid_en, idex_flush} !== 3'b001) begin fails++; $display("FAIL load_use stall: got %b exp 001", {pc_en, ifid_en, idex_flush}); end
    tests++;
    if (dut_out() !== exp) begin fails++; $display("FAIL load_use model: got %h exp %h", dut_out(), exp); end
    tests++;
    advance();
    ex_is_load = 0;
    settle();
    if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin fails++; $display("FAIL load_use bubble_once: got %b exp 110", {pc_en, ifid_en, idex_flush}); end
    tests++;
    advance();
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
    settle();
    if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin fails++; $display("FAIL load_use x0: got %b exp 110", {pc_en, ifid_en, idex_flush}); end
    tests++;
    advance();
    ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_rs2_used = 1;
    settle();
    if ({pc_en, ifid_en, idex_flush} !== 3'b001) begin fails++; $display("FAIL load_use rs2: got %b exp 001", {pc_en, ifid_en, idex_flush}); end
    tests++;
    advance();
    id_rs2_used = 0;
    settle();
    if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin fails++; $display("FAIL load_use rs2_unused: got %b exp 110", {pc_en, ifid_en, idex_flush}); end
    tests++;
    advance();
  endtask
  task automatic test_redirect();
    idle(); ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1; ex_redirect = 1;
    settle();
    if ({pc_en, pc_sel, ifid_flush, idex_flush} !== 5'b1_01_11) begin fails++; $display("FAIL redirect_over_lu: got %b exp 10111", {pc_en, pc_sel, ifid_flush, idex_flush}); end
    tests++;
    if (dut_out() !== exp) begin fails++; $display("FAIL redirect model: got %h exp %h", dut_out(), exp); end
    tests++;
    advance();
    idle(); if_valid = 0;
    settle();
    if ({pc_en, ifid_flush, idex_en, exmem_en} !== 4'b0111) begin fails++; $display("FAIL no_fetch: got %b exp 0111", {pc_en, ifid_flush, idex_en, exmem_en}); end
    tests++;
    advance();
  endtask
  task automatic test_mem_wait();
    idle(); mem_req = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      if ({pc_en, memwb_flush, exmem_en, state} !== {2'b01, 1'b0, (i == 0) ? 2'd0 : 2'd1}) begin
        fails++; $display("FAIL mem_wait cyc%0d: got pc_en=%b memwb_flush=%b state=%0d", i, pc_en, memwb_flush, state);
      end
      tests++;
      if (dut_out() !== exp) begin fails++; $display("FAIL mem_wait model: got %h exp %h", dut_out(), exp); end
      tests++;
      advance();
    end
    mem_ready = 1;
    settle();
    if ({state, pc_en, ifid_en, idex_en, exmem_en, memwb_en, memwb_flush} !== 8'b01_11111_0) begin
      fails++; $display("FAIL mem_release: got %b exp 01111110", {state, pc_en, ifid_en, idex_en, exmem_en, memwb_en, memwb_flush});
    end
    tests++;
    advance();
    idle();
    settle();
    if (state !== 2'd0) begin fails++; $display("FAIL mem_back_run: got %0d exp 0", state); end
    tests++;
    advance();
  endtask
  task automatic test_trap_mem();
    idle(); mem_req = 1;
    settle(); advance();
    trap = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      if ({trap_ack, state} !== 3'b0_01) begin fails++; $display("FAIL trap_in_mem_ignored: got ack=%b state=%0d", trap_ack, state); end
      tests++;
      advance();
    end
    mem_ready = 1;
    settle();
    if ({pc_en, ifid_flush, idex_flush, exmem_flush, memwb_flush, trap_ack} !== 6'b0_1111_0) begin
      fails++; $display("FAIL trap_taken: got %b exp 011110", {pc_en, ifid_flush, idex_flush, exmem_flush, memwb_flush, trap_ack});
    end
    tests++;
    advance();
    mem_req = 0; mem_ready = 0;
    for (int i = 0; i < D; i++) begin
      settle();
      if ({state, trap_ack, pc_en, pc_sel} !== ((i == D - 1) ? 6'b11_1_1_10 : 6'b11_0_0_00)) begin
        fails++; $display("FAIL trap_drain%0d: got state=%0d ack=%b pc_en=%b sel=%b", i, state, trap_ack, pc_en, pc_sel);
      end
      tests++;
      if (dut_out() !== exp) begin fails++; $display("FAIL trap_drain model: got %h exp %h", dut_out(), exp); end
      tests++;
      advance();
    end
    trap = 0;
    settle();
    if (state !== 2'd0 || trap_ack !== 1'b0) begin fails++; $display("FAIL trap_done: got state=%0d ack=%b", state, trap_ack); end
    tests++;
    advance();
  endtask
  task automatic test_mdu_trap();
    idle(); ex_mdu_start = 1;
    settle(); advance();
    settle();
    if ({state, exmem_flush, memwb_en, pc_en, mdu_kill} !== 6'b10_1_1_0_0) begin
      fails++; $display("FAIL mdu_wait: got state=%0d exmem_flush=%b pc_en=%b kill=%b", state, exmem_flush, pc_en, mdu_kill);
    end
    tests++;
    advance();
    trap = 1;
    settle();
    if ({mdu_kill, state, pc_en, trap_ack} !== 5'b1_10_0_0) begin fails++; $display("FAIL mdu_kill: got kill=%b state=%0d pc_en=%b", mdu_kill, state, pc_en); end
    tests++;
    advance();
    ex_mdu_start = 0;
    for (int i = 0; i < D; i++) begin
      settle();
      if ({mdu_kill, trap_ack, state} !== {1'b0, i == D - 1, 2'd3}) begin
        fails++; $display("FAIL mdu_trap_drain%0d: got kill=%b ack=%b state=%0d", i, mdu_kill, trap_ack, state);
      end
      tests++;
      advance();
    end
    trap = 0;
  endtask
  task automatic test_reset_in_mdu();
    idle(); ex_mdu_start = 1;
    settle(); advance();
    rst = 0;
    settle();
    if ({ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_en, mdu_kill} !== 6'b1111_00) begin
      fails++; $display("FAIL rst_in_mdu: got %b exp 111100", {ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_en, mdu_kill});
    end
    tests++;
    advance();
    idle(); ex_redirect = 1;
    settle();
    if (state !== 2'd0) begin fails++; $display("FAIL rst_state: got %0d exp 0", state); end
    tests++;
    if ({perf_stall_cnt, perf_flush_cnt} !== exp_perf()) begin fails++; $display("FAIL perf_after_rst: got %h exp %h", {perf_stall_cnt, perf_flush_cnt}, exp_perf()); end
    tests++;
    advance();
    idle();
    settle();
    if ({perf_stall_cnt, perf_flush_cnt} !== exp_perf()) begin fails++; $display("FAIL perf_redirect: got %h exp %h", {perf_stall_cnt, perf_flush_cnt}, exp_perf()); end
    tests++;
    advance();
  endtask
  task automatic test_random();
    bit hold = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 49) != 0;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7)); ex_rd = 5'($urandom_range(0, 7));
      id_rs1_used = $urandom_range(0, 1) == 1; id_rs2_used = $urandom_range(0, 1) == 1;
      ex_is_load = $urandom_range(0, 1) == 1; ex_redirect = $urandom_range(0, 5) == 0;
      ex_mdu_start = $urandom_range(0, 4) == 0; mdu_done = $urandom_range(0, 2) == 0;
      mem_req = $urandom_range(0, 2) == 0; mem_ready = $urandom_range(0, 1) == 1;
      if_valid = $urandom_range(0, 3) != 0;
      trap = hold || $urandom_range(0, 19) == 0;
      settle();
      if (dut_out() !== exp) begin fails++; $display("FAIL random cyc%0d: got %h exp %h", i, dut_out(), exp); end
      tests++;
      if ({perf_stall_cnt, perf_flush_cnt} !== exp_perf()) begin fails++; $display("FAIL random_perf cyc%0d: got %h exp %h", i, {perf_stall_cnt, perf_flush_cnt}, exp_perf()); end
      tests++;
      hold = trap && rst && !exp[3];
      advance();
    end
    idle();
  endtask
  initial begin
    idle(); rst = 0;
    repeat (2) @(posedge clk);
    #1;
    m_st = 0; m_cnt = 0; m_ps = 0; m_pf = 0;
    rst = 0;
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_trap_mem();
    test_mdu_trap();
    test_reset_in_mdu();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
